// File: rtl/wb_ram_pkg.sv
// Shared constants and helpers for the Wishbone RAM slave.
package wb_ram_pkg;

  // Width of the per-access wait counter (WAITCYCLES is at most 15).
  localparam int CNT_W = 4;

  // Number of byte lanes for a given data width.
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Byte-enabled synchronous single-port memory. Reads return data one
// clock after the enabled edge; writes update only the selected lanes.
module wb_ram_array
  import wb_ram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int SIZE  = 'h1000,
  parameter int ABITS = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [lanes(DW)-1:0] sel,
  input  logic [ABITS-1:0]     adr,
  input  logic [DW-1:0]        d,
  output logic [DW-1:0]        q
);

  localparam int NL = lanes(DW);

  logic [DW-1:0] mem_q [SIZE];

  // Lane-masked write, or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NL; i++) begin
          if (sel[i]) mem_q[adr][i*8 +: 8] <= d[i*8 +: 8];
        end
      end else begin
        q <= mem_q[adr];
      end
    end
  end

endmodule

// File: rtl/wb_ram.sv
// Wishbone B4 pipelined RAM slave with programmable wait states.
// Optional macro WB_RAM_ERR_EN adds wb_err for addresses >= SIZE;
// without it upper address bits are ignored and accesses wrap.
module wb_ram
  import wb_ram_pkg::*;
#(
  parameter int DW         = 16,
  parameter int SIZE       = 'h1000,
  parameter int AW         = 16,
  parameter int WAITCYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_adr,
  input  logic [DW-1:0]        wb_dat_i,
  input  logic [lanes(DW)-1:0] wb_sel,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_ack,
  output logic                 wb_stall
`ifdef WB_RAM_ERR_EN
  ,
  output logic                 wb_err
`endif
);

  localparam int               ABITS   = $clog2(SIZE);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(WAITCYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;
  logic             valid, accept, oob;
  logic [DW-1:0]    q;

  assign valid    = wb_cyc & wb_stb;
  assign wb_stall = valid & (cnt_q != '0);
  // Nothing is accepted while reset is asserted, so no write or ack leaks out.
  assign accept   = valid & ~wb_stall & rst_n;

`ifdef WB_RAM_ERR_EN
  assign oob    = ({1'b0, wb_adr} >= (AW+1)'(SIZE));
  assign wb_err = err_q;
`else
  logic unused_adr;
  assign oob        = 1'b0;
  assign unused_adr = ^wb_adr;
`endif

  // Wait counter: reload on abort or accept, count down while strobed.
  always_comb begin
    cnt_d = cnt_q;
    ack_d = accept & ~oob;
    rd_d  = accept & ~oob & ~wb_we;
    err_d = accept & oob;
    if (!wb_cyc || accept)          cnt_d = CNT_RST;
    else if (valid && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Handshake registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_RST;
      ack_q <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      rd_q  <= rd_d;
      err_q <= err_d;
    end
  end

  assign wb_ack   = ack_q;
  // Data bus is quiet except during a read acknowledge.
  assign wb_dat_o = (ack_q && rd_q) ? q : '0;

  wb_ram_array #(.DW(DW), .SIZE(SIZE), .ABITS(ABITS)) u_array (
    .clk (clk),
    .en  (accept & ~oob),
    .we  (wb_we),
    .sel (wb_sel),
    .adr (wb_adr[ABITS-1:0]),
    .d   (wb_dat_i),
    .q   (q)
  );

endmodule

// File: tb/tb_wb_ram.sv
// Bench for wb_ram: three instances with WAITCYCLES 0, 2 and 3.
module tb_wb_ram;
  localparam int DW = 16, AW = 16, SIZE = 'h1000, NL = 2, ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic          cyc [ND], stb [ND], we [ND];
  logic [AW-1:0] adr [ND];
  logic [DW-1:0] dat_i [ND], dat_o [ND];
  logic [NL-1:0] sel [ND];
  logic          ack [ND], stall [ND], err [ND];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [SIZE];  // model of instance 0

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_ram #(.DW(DW), .SIZE(SIZE), .AW(AW),
             .WAITCYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[g]), .wb_stb(stb[g]), .wb_we(we[g]),
      .wb_adr(adr[g]), .wb_dat_i(dat_i[g]), .wb_sel(sel[g]), .wb_dat_o(dat_o[g]),
      .wb_ack(ack[g]), .wb_stall(stall[g])
`ifdef WB_RAM_ERR_EN
      , .wb_err(err[g])
`endif
    );
`ifndef WB_RAM_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NL-1:0] s);
    logic [DW-1:0] m;
    m = {{8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // One complete single access; holds strobe until accepted, then samples
  // the two cycles after the accept edge.
  task automatic access(input int d, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] v, input logic [NL-1:0] s,
                        output int stalls, output bit tmo, output logic a1, output logic e1,
                        output logic [DW-1:0] rd, output logic a2, output logic e2);
    @(posedge clk); #1;
    cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; dat_i[d] = v; sel[d] = s;
    stalls = 0; tmo = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall[d]) begin tmo = 0; break; end
      stalls++;
    end
    @(posedge clk); #1; stb[d] = 0; we[d] = 0;
    @(negedge clk); a1 = ack[d]; e1 = err[d]; rd = dat_o[d];
    @(posedge clk); #1; cyc[d] = 0;
    @(negedge clk); a2 = ack[d]; e2 = err[d];
  endtask

  task automatic test_reset;
    rst_n = 0;
    for (int d = 0; d < ND; d++) begin
      cyc[d] = 1; stb[d] = 1; we[d] = 0; adr[d] = '0; dat_i[d] = '0; sel[d] = '1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL rst_ack[%0d] got %b exp 0", d, ack[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL rst_err[%0d] got %b exp 0", d, err[d]); end
      checks++; if (dat_o[d] !== '0) begin errors++; $display("FAIL rst_dat[%0d] got %h exp 0", d, dat_o[d]); end
      checks++; if (stall[d] !== (d != 0)) begin errors++; $display("FAIL rst_stall[%0d] got %b exp %b", d, stall[d], d != 0); end
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin cyc[d] = 0; stb[d] = 0; end
    rst_n = 1;
    @(negedge clk);
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL rst_noack got %b exp 0", ack[0]); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 5; dat_i[0] = 'h1234; sel[0] = 2'b11;
    @(negedge clk);
    checks++; if (stall[0] !== 1'b0 || ack[0] !== 1'b0) begin errors++; $display("FAIL b2b_c0 got stall %b ack %b exp 0 0", stall[0], ack[0]); end
    @(posedge clk); #1; we[0] = 0;
    @(negedge clk);
    checks++; if (stall[0] !== 1'b0 || ack[0] !== 1'b1) begin errors++; $display("FAIL b2b_c1 got stall %b ack %b exp 0 1", stall[0], ack[0]); end
    @(posedge clk); #1; stb[0] = 0;
    @(negedge clk);
    checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL b2b_c2_ack got %b exp 1", ack[0]); end
    checks++; if (dat_o[0] !== 16'h1234) begin errors++; $display("FAIL b2b_rdata got %h exp 1234", dat_o[0]); end
    @(posedge clk); #1; cyc[0] = 0;
    @(negedge clk);
    checks++; if (ack[0] !== 1'b0 || dat_o[0] !== '0) begin errors++; $display("FAIL b2b_c3 got ack %b dat %h exp 0 0", ack[0], dat_o[0]); end
  endtask

  task automatic test_wait_states;
    int st; bit tmo; logic a1, e1, a2, e2; logic [DW-1:0] rd, v;
    v = DW'($urandom);
    access(2, 1, 7, v, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    access(2, 0, 7, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wait_timeout got %b exp 0", tmo); end
    checks++; if (st != 3) begin errors++; $display("FAIL wait_stalls got %0d exp 3", st); end
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL wait_ack got %b%b exp 10", a1, a2); end
    checks++; if (rd !== v) begin errors++; $display("FAIL wait_rdata got %h exp %h", rd, v); end
  endtask

  task automatic test_byte_lanes;
    int st; bit tmo; logic a1, e1, a2, e2; logic [DW-1:0] rd, v, exp_v;
    logic [NL-1:0] s; logic [AW-1:0] a;
    access(0, 1, 9, 'hAAAA, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    access(0, 1, 9, 'h5533, 2'b10, st, tmo, a1, e1, rd, a2, e2);
    access(0, 0, 9, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (rd !== 16'h55AA) begin errors++; $display("FAIL lane_merge got %h exp 55aa", rd); end
    access(0, 1, 9, 'hFFFF, 2'b00, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL lane_sel0_ack got %b exp 1", a1); end
    access(0, 0, 9, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (rd !== 16'h55AA) begin errors++; $display("FAIL lane_sel0_keep got %h exp 55aa", rd); end
    // Random lane writes over a known base value on instance 3's neighbour (W=2).
    for (int i = 0; i < 6; i++) begin
      a = AW'(40 + i); exp_v = DW'($urandom);
      access(1, 1, a, exp_v, 2'b11, st, tmo, a1, e1, rd, a2, e2);
      v = DW'($urandom); s = NL'($urandom_range(0, 3));
      access(1, 1, a, v, s, st, tmo, a1, e1, rd, a2, e2);
      exp_v = merge(exp_v, v, s);
      access(1, 0, a, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
      checks++; if (rd !== exp_v) begin errors++; $display("FAIL lane_rand[%0d] sel %b got %h exp %h", i, s, rd, exp_v); end
    end
  endtask

  task automatic test_abort;
    int st; bit tmo; logic a1, e1, a2, e2; logic [DW-1:0] rd;
    access(1, 1, 3, 'h0F0F, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 3; dat_i[1] = 'hDEAD; sel[1] = 2'b11;
    @(negedge clk);
    checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL abort_stall got %b exp 1", stall[1]); end
    @(posedge clk); #1; cyc[1] = 0; stb[1] = 0; we[1] = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ack[1] !== 1'b0) begin errors++; $display("FAIL abort_noack[%0d] got %b exp 0", k, ack[1]); end
    end
    access(1, 0, 3, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (st != 2) begin errors++; $display("FAIL abort_restart_stalls got %0d exp 2", st); end
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL abort_restart_ack got %b%b exp 10", a1, a2); end
    checks++; if (rd !== 16'h0F0F) begin errors++; $display("FAIL abort_nowrite got %h exp 0f0f", rd); end
  endtask

  task automatic test_reset_mid;
    int st; bit tmo; logic a1, e1, a2, e2; logic [DW-1:0] rd, v;
    v = DW'($urandom);
    access(2, 1, 20, v, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    @(posedge clk); #1;
    cyc[2] = 1; stb[2] = 1; we[2] = 0; adr[2] = 20; sel[2] = 2'b11;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 0;
    @(negedge clk);
    checks++; if (ack[2] !== 1'b0) begin errors++; $display("FAIL rmid_ack_b got %b exp 0", ack[2]); end
    @(posedge clk); #1; rst_n = 1; stb[2] = 0;
    @(negedge clk);
    checks++; if (ack[2] !== 1'b0) begin errors++; $display("FAIL rmid_ack_c got %b exp 0", ack[2]); end
    access(2, 0, 20, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (st != 3) begin errors++; $display("FAIL rmid_cnt_reload got %0d exp 3", st); end
    checks++; if (rd !== v) begin errors++; $display("FAIL rmid_mem_kept got %h exp %h", rd, v); end
  endtask

  task automatic test_out_of_range;
    int st; bit tmo; logic a1, e1, a2, e2; logic [DW-1:0] rd;
    access(0, 1, 0, 'h1111, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    access(0, 1, 'h1000, 'hBEEF, 2'b11, st, tmo, a1, e1, rd, a2, e2);
`ifdef WB_RAM_ERR_EN
    checks++; if (a1 !== 1'b0 || e1 !== 1'b1 || e2 !== 1'b0) begin errors++; $display("FAIL oob_err got ack %b err %b%b exp 0 10", a1, e1, e2); end
    access(0, 0, 0, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL oob_nowrite got %h exp 1111", rd); end
`else
    checks++; if (a1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL oob_wrap_ack got ack %b err %b exp 1 0", a1, e1); end
    access(0, 0, 0, '0, 2'b11, st, tmo, a1, e1, rd, a2, e2);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL oob_wrap_write got %h exp beef", rd); end
`endif
  endtask

  // Pipelined random traffic on the zero-wait instance against ref_mem.
  task automatic test_random_pipelined;
    bit pv = 0, prd = 0, v, w;
    logic [DW-1:0] pexp = '0, d;
    logic [AW-1:0] a;
    logic [NL-1:0] s;
    for (int i = 0; i < 300; i++) begin
      v = (i < 16) ? 1'b1 : ($urandom_range(0, 3) != 0);
      w = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      a = (i < 16) ? AW'(i) : AW'($urandom_range(0, 15));
      s = (i < 16) ? 2'b11 : NL'($urandom_range(0, 3));
      d = DW'($urandom);
      @(posedge clk); #1;
      cyc[0] = 1; stb[0] = v; we[0] = w; adr[0] = a; dat_i[0] = d; sel[0] = s;
      @(negedge clk);
      checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp 0", i, stall[0]); end
      checks++; if (ack[0] !== pv) begin errors++; $display("FAIL rnd_ack[%0d] got %b exp %b", i, ack[0], pv); end
      checks++; if (dat_o[0] !== ((pv && prd) ? pexp : '0)) begin
        errors++; $display("FAIL rnd_dat[%0d] got %h exp %h", i, dat_o[0], (pv && prd) ? pexp : '0);
      end
      prd = v && !w;
      if (v && !w) pexp = ref_mem[a];
      if (v && w)  ref_mem[a] = merge(ref_mem[a], d, s);
      pv = v;
    end
    @(posedge clk); #1; stb[0] = 0;
    @(negedge clk);
    checks++; if (ack[0] !== pv) begin errors++; $display("FAIL rnd_last_ack got %b exp %b", ack[0], pv); end
    @(posedge clk); #1; cyc[0] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_wait_states;
    test_byte_lanes;
    test_abort;
    test_reset_mid;
    test_out_of_range;
    test_random_pipelined;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ram.md
WB_RAM -- requirements
Module: wb_ram

Interface
REQ-001 SHALL have parameter DW, default 16: data width in bits, multiple of 8, range 8..64.
REQ-002 SHALL have parameter SIZE, default 'h1000: depth in words, power of two.
REQ-003 SHALL have parameter AW, default 16: bus address width, AW >= $clog2(SIZE).
REQ-004 SHALL have parameter WAITCYCLES, default 0: stall cycles per access, range 0..15.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port wb_cyc, input, 1: bus cycle.
REQ-008 SHALL have port wb_stb, input, 1: strobe.
REQ-009 SHALL have port wb_we, input, 1: write enable.
REQ-010 SHALL have port wb_adr, input, AW: word address.
REQ-011 SHALL have port wb_dat_i, input, DW: write data.
REQ-012 SHALL have port wb_sel, input, DW/8: byte-lane select.
REQ-013 SHALL have port wb_dat_o, output, DW: read data.
REQ-014 SHALL have port wb_ack, output, 1: acknowledge.
REQ-015 SHALL have port wb_stall, output, 1: pipeline stall.
REQ-016 SHALL have port wb_err, output, 1: error acknowledge, present only with WB_RAM_ERR_EN.

Function
REQ-017 SHALL follow Wishbone B4 classic pipelined protocol; valid = wb_cyc & wb_stb.
REQ-018 SHALL contain a wait counter: reset value WAITCYCLES, 4 bits.
REQ-019 SHALL drive wb_stall = valid & (cnt != 0), combinationally.
REQ-020 SHALL decrement cnt each cycle valid is high and cnt != 0; SHALL hold cnt while wb_cyc high and wb_stb low.
REQ-021 SHALL accept a request in a cycle with valid high and wb_stall low; on acceptance cnt reloads WAITCYCLES.
REQ-022 SHALL reload cnt to WAITCYCLES in any cycle wb_cyc is low (abort); the pending request is dropped with no ack and no write.
REQ-023 SHALL register wb_ack: wb_ack high exactly in the cycle after each accept, one cycle per accepted request.
REQ-024 With WAITCYCLES=0, SHALL sustain one accept and one ack per cycle back-to-back.
REQ-025 On an accepted write, SHALL update byte lane i at the accept edge only where wb_sel[i]=1; lanes with wb_sel[i]=0 are preserved; wb_sel=0 acks with no change.
REQ-026 On an accepted read, SHALL present memory data on wb_dat_o together with wb_ack; read-after-write to the same address in consecutive accepts SHALL return the new data.
REQ-027 wb_dat_o SHALL be 0 whenever wb_ack is low.
REQ-028 Memory array address SHALL be wb_adr[$clog2(SIZE)-1:0].

Reset
REQ-029 While rst_n low at a clk edge: wb_ack=0, wb_err=0, cnt=WAITCYCLES, wb_dat_o=0.
REQ-030 Reset mid-access SHALL drop any pending request without ack or write; memory contents are not cleared.

Configuration
REQ-031 Macro WB_RAM_ERR_EN defined: an accept with wb_adr >= SIZE SHALL assert wb_err (not wb_ack) the next cycle, suppress the write, and return wb_dat_o=0.
REQ-032 Macro WB_RAM_ERR_EN undefined: no wb_err port; upper address bits ignored, addresses wrap modulo SIZE and ack normally.

Structure
REQ-033 Package wb_ram_pkg SHALL hold the wait-counter width constant and the lane-count function (DW/8).
REQ-034 Sub-module wb_ram_array SHALL implement the byte-enabled synchronous single-port memory (clk, en, we, sel, adr, d, q); wb_ram holds the counter, handshake and error logic.

Verification
REQ-035 WAITCYCLES=0: write 'h1234 to 5 then read 5 back-to-back -> stall never high, acks in cycles 1 and 2 after first strobe, read data 'h1234.
REQ-036 WAITCYCLES=3: single read of 7 -> wb_stall high 3 cycles, accept on 4th, wb_ack one cycle later, exactly one ack.
REQ-037 DW=16: write 'hAAAA, then write 'h55xx with wb_sel=2'b10 -> read returns 'h55AA.
REQ-038 WAITCYCLES=2: drop wb_cyc after 1 stall cycle, restart read -> no ack for aborted request, new request sees full 2 stall cycles.
REQ-039 rst_n low for one cycle during stall -> wb_ack stays 0, cnt reloads, prior memory contents intact on next read.
REQ-040 SIZE='h1000, WB_RAM_ERR_EN: write to 'h1000 -> wb_err pulse, no ack, location 0 unchanged; without macro -> ack, location 0 written.
